// File: rtl/piece_drop_ctrl.sv
// ---------------------------------------------------------------------------
// piece_drop_ctrl
//
// Write-side controller for the Connect4 board RAM.  Given a "drop a piece in
// column c" request it walks that column from the bottom row upwards, looking
// for the lowest empty cell in the packed board image, and issues a single RAM
// write of the player code into that cell.  It can also wipe the whole board:
// one zero write per cell, one per cycle.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; aborts any operation in flight
//   req_valid    drop request valid
//   req_ready    high while idle; a request is taken when valid & ready
//   req_col      target column, 0..COLS-1
//   req_player   piece code, 1 or 2 (0 means an empty cell)
//   clr          board-clear command, only looked at while idle
//   board        packed RAM image, cell k at [k*DATA_WIDTH +: DATA_WIDTH]
//   addr         RAM write address (cell index = row*COLS + col)
//   write_data   RAM write data (player code zero-extended, or 0 when clearing)
//   memwrite_en  RAM write strobe, one cycle per write
//   done_valid   one-cycle completion pulse
//   done_ok      1 = write(s) performed, 0 = rejected request or full column
//   done_row     row written by the last successful drop (0 after a clear)
// ---------------------------------------------------------------------------
module piece_drop_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int ROWS          = 6,
  parameter int COLS          = 7,
  parameter int MEM_DEPTH     = 42
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [2:0]                      req_col,
  input  logic [1:0]                      req_player,
  input  logic                            clr,
  input  logic [DATA_WIDTH*MEM_DEPTH-1:0] board,
  output logic [ADDRESS_WIDTH-1:0]        addr,
  output logic [DATA_WIDTH-1:0]           write_data,
  output logic                            memwrite_en,
  output logic                            done_valid,
  output logic                            done_ok,
  output logic [2:0]                      done_row
);

  // State encoding
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SCAN  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] CLEAR = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  // Sized copies of the geometry so every compare and add is width-matched
  localparam logic [2:0]               LAST_ROW  = 3'(ROWS - 1);
  localparam logic [3:0]               NUM_COLS  = 4'(COLS);
  localparam logic [ADDRESS_WIDTH-1:0] COLS_A    = ADDRESS_WIDTH'(COLS);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_CELL = ADDRESS_WIDTH'(MEM_DEPTH - 1);

  logic [2:0]               state_q,     state_d;
  logic [2:0]               col_q,       col_d;
  logic [1:0]               player_q,    player_d;
  logic [2:0]               row_q,       row_d;
  logic [ADDRESS_WIDTH-1:0] cellCnt_q,   cellCnt_d;
  logic                     ok_q,        ok_d;
  logic [ADDRESS_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q,     wdata_d;
  logic                     wen_q,       wen_d;
  logic                     doneValid_q, doneValid_d;
  logic                     doneOk_q,    doneOk_d;
  logic [2:0]               doneRow_q,   doneRow_d;

  logic [ADDRESS_WIDTH-1:0] cellIdx;
  logic                     cellOccupied;
  logic                     reqInvalid;

  // Index of the cell currently under inspection in the latched column
  assign cellIdx = ADDRESS_WIDTH'(row_q) * COLS_A + ADDRESS_WIDTH'(col_q);

  // A request is rejected outright if the column is off the board or the
  // player code is not a real piece
  assign reqInvalid = ({1'b0, req_col} >= NUM_COLS) ||
                      ((req_player != 2'd1) && (req_player != 2'd2));

  // Select the inspected cell out of the packed image.  Any nonzero bit in
  // the full word counts as occupied, not just the low player-code bits.
  always_comb begin
    cellOccupied = 1'b0;
    for (int k = 0; k < MEM_DEPTH; k++) begin
      if (cellIdx == ADDRESS_WIDTH'(k)) begin
        cellOccupied = |board[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic.  All visible outputs are computed here and registered,
  // so each output appears one cycle after the state that decides it: the
  // write strobe shows while the FSM is already in RESP, and done_valid shows
  // while it is back in IDLE, which lets a new request be taken on that cycle.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    player_d    = player_q;
    row_d       = row_q;
    cellCnt_d   = cellCnt_q;
    ok_d        = ok_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    doneValid_d = 1'b0;
    doneOk_d    = doneOk_q;
    doneRow_d   = doneRow_q;

    case (state_q)
      IDLE: begin
        // Clear has priority; a request presented alongside it is dropped
        if (clr) begin
          cellCnt_d = '0;
          state_d   = CLEAR;
        end else if (req_valid) begin
          col_d    = req_col;
          player_d = req_player;
          row_d    = 3'd0;
          if (reqInvalid) begin
            ok_d    = 1'b0;
            state_d = RESP;
          end else begin
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        // One row per cycle, bottom-up; stop at the first empty cell or give
        // up once the top row is also occupied
        if (!cellOccupied) begin
          state_d = WRITE;
        end else if (row_q == LAST_ROW) begin
          ok_d    = 1'b0;
          state_d = RESP;
        end else begin
          row_d = row_q + 3'd1;
        end
      end

      WRITE: begin
        wen_d   = 1'b1;
        addr_d  = cellIdx;
        wdata_d = DATA_WIDTH'(player_q);
        ok_d    = 1'b1;
        state_d = RESP;
      end

      CLEAR: begin
        // Sweep every cell once; done_row reports 0 after a clear
        wen_d   = 1'b1;
        addr_d  = cellCnt_q;
        wdata_d = '0;
        if (cellCnt_q == LAST_CELL) begin
          ok_d    = 1'b1;
          row_d   = 3'd0;
          state_d = RESP;
        end else begin
          cellCnt_d = cellCnt_q + 1'b1;
        end
      end

      RESP: begin
        doneValid_d = 1'b1;
        doneOk_d    = ok_q;
        doneRow_d   = row_q;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.  Reset clears the write strobe immediately,
  // so an interrupted clear leaves no stray write behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      player_q    <= '0;
      row_q       <= '0;
      cellCnt_q   <= '0;
      ok_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      doneValid_q <= 1'b0;
      doneOk_q    <= 1'b0;
      doneRow_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      player_q    <= player_d;
      row_q       <= row_d;
      cellCnt_q   <= cellCnt_d;
      ok_q        <= ok_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      doneValid_q <= doneValid_d;
      doneOk_q    <= doneOk_d;
      doneRow_q   <= doneRow_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign addr        = addr_q;
  assign write_data  = wdata_q;
  assign memwrite_en = wen_q;
  assign done_valid  = doneValid_q;
  assign done_ok     = doneOk_q;
  assign done_row    = doneRow_q;

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// ---------------------------------------------------------------------------
// tb_piece_drop_ctrl
//
// Directed bench for piece_drop_ctrl.  Each scenario task builds a board
// image, issues one operation and compares write timing, address, data and
// the completion response against hand-computed values.
// ---------------------------------------------------------------------------
module tb_piece_drop_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int NROWS = 6;
  localparam int NCOLS = 7;
  localparam int DEPTH = 42;

  logic                  clk;
  logic                  rst_n;
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_col;
  logic [1:0]            req_player;
  logic                  clr;
  logic [DW*DEPTH-1:0]   board;
  logic [AW-1:0]         addr;
  logic [DW-1:0]         write_data;
  logic                  memwrite_en;
  logic                  done_valid;
  logic                  done_ok;
  logic [2:0]            done_row;

  int passCount;
  int checkCount;

  // Observations gathered by runOp
  int          wrCycle;
  int          wrCount;
  int          firstAddr;
  int          lastAddr;
  logic [31:0] wrData;
  logic        seqOk;
  logic        zeroOk;
  logic        readyBusyOk;
  logic        readyAtReq;
  int          doneCycle;
  logic        doneOkSeen;
  logic [2:0]  doneRowSeen;

  piece_drop_ctrl #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .ROWS         (NROWS),
    .COLS         (NCOLS),
    .MEM_DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_col    (req_col),
    .req_player (req_player),
    .clr        (clr),
    .board      (board),
    .addr       (addr),
    .write_data (write_data),
    .memwrite_en(memwrite_en),
    .done_valid (done_valid),
    .done_ok    (done_ok),
    .done_row   (done_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setCell(input int row, input int col, input logic [31:0] val);
    board[(row*NCOLS + col)*DW +: DW] = val;
  endtask

  // Present one operation on a falling edge, take the next rising edge as
  // cycle 0 and watch cycles 1..budget, stopping on the first done pulse
  task automatic runOp(input logic clrIn, input logic reqIn, input logic [2:0] col,
                       input logic [1:0] player, input int budget);
    @(negedge clk);
    clr        = clrIn;
    req_valid  = reqIn;
    req_col    = col;
    req_player = player;
    #1;
    readyAtReq = req_ready;
    @(posedge clk);
    #1;
    clr       = 1'b0;
    req_valid = 1'b0;
    wrCycle     = -1;
    wrCount     = 0;
    firstAddr   = -1;
    lastAddr    = -1;
    wrData      = '0;
    seqOk       = 1'b1;
    zeroOk      = 1'b1;
    readyBusyOk = 1'b1;
    doneCycle   = -1;
    doneOkSeen  = 1'b0;
    doneRowSeen = '0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (memwrite_en) begin
        if (wrCount == 0) begin
          wrCycle   = k;
          firstAddr = int'(addr);
        end
        if (int'(addr) != wrCount) seqOk = 1'b0;
        if (write_data != '0) zeroOk = 1'b0;
        wrData   = write_data;
        lastAddr = int'(addr);
        wrCount++;
      end
      if (done_valid) begin
        doneCycle   = k;
        doneOkSeen  = done_ok;
        doneRowSeen = done_row;
        break;
      end else if (req_ready) begin
        readyBusyOk = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_col    = '0;
    req_player = '0;
    clr        = 1'b0;
    board      = '0;
    #3;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready);
    else passCount++;
    checkCount++;
    if (memwrite_en !== 1'b0) $display("FAIL reset_wen: got %b expected 0", memwrite_en);
    else passCount++;
    checkCount++;
    if (done_valid !== 1'b0 || done_ok !== 1'b0 || done_row !== 3'd0)
      $display("FAIL reset_done: got valid=%b ok=%b row=%0d expected 0/0/0", done_valid, done_ok, done_row);
    else passCount++;
    checkCount++;
    if (addr !== '0 || write_data !== '0)
      $display("FAIL reset_addr_data: got addr=%0d data=%0h expected 0/0", addr, write_data);
    else passCount++;
    checkCount++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_empty_drop();
    board = '0;
    runOp(1'b0, 1'b1, 3'd3, 2'd1, 20);
    if (readyAtReq !== 1'b1) $display("FAIL empty_ready: got %b expected 1", readyAtReq);
    else passCount++;
    checkCount++;
    if (wrCycle != 2 || wrCount != 1)
      $display("FAIL empty_wr_timing: got cycle=%0d count=%0d expected 2/1", wrCycle, wrCount);
    else passCount++;
    checkCount++;
    if (firstAddr != 3 || wrData !== 32'd1)
      $display("FAIL empty_wr_addr_data: got addr=%0d data=%0h expected 3/1", firstAddr, wrData);
    else passCount++;
    checkCount++;
    if (doneCycle != 3 || doneOkSeen !== 1'b1 || doneRowSeen !== 3'd0)
      $display("FAIL empty_done: got cycle=%0d ok=%b row=%0d expected 3/1/0", doneCycle, doneOkSeen, doneRowSeen);
    else passCount++;
    checkCount++;
    if (readyBusyOk !== 1'b1) $display("FAIL empty_busy_ready: got ready high while busy expected low");
    else passCount++;
    checkCount++;
    @(posedge clk);
    #1;
    if (done_valid !== 1'b0 || done_ok !== 1'b1)
      $display("FAIL empty_done_hold: got valid=%b ok=%b expected 0/1", done_valid, done_ok);
    else passCount++;
    checkCount++;
  endtask

  task automatic test_stacked_drop();
    board = '0;
    setCell(0, 3, 32'd1);
    setCell(1, 3, 32'd2);
    setCell(2, 3, 32'd1);
    runOp(1'b0, 1'b1, 3'd3, 2'd2, 20);
    if (wrCycle != 5 || firstAddr != 24 || wrData !== 32'd2)
      $display("FAIL stacked_wr: got cycle=%0d addr=%0d data=%0h expected 5/24/2", wrCycle, firstAddr, wrData);
    else passCount++;
    checkCount++;
    if (doneCycle != 6 || doneOkSeen !== 1'b1 || doneRowSeen !== 3'd3)
      $display("FAIL stacked_done: got cycle=%0d ok=%b row=%0d expected 6/1/3", doneCycle, doneOkSeen, doneRowSeen);
    else passCount++;
    checkCount++;
  endtask

  task automatic test_full_column();
    board = '0;
    setCell(0, 6, 32'd1);
    setCell(1, 6, 32'd2);
    setCell(2, 6, 32'd1);
    setCell(3, 6, 32'd2);
    setCell(4, 6, 32'h0001_0000);
    setCell(5, 6, 32'h8000_0000);
    runOp(1'b0, 1'b1, 3'd6, 2'd1, 20);
    if (wrCount != 0) $display("FAIL full_no_write: got %0d writes expected 0", wrCount);
    else passCount++;
    checkCount++;
    if (doneCycle != 7 || doneOkSeen !== 1'b0)
      $display("FAIL full_done: got cycle=%0d ok=%b expected 7/0", doneCycle, doneOkSeen);
    else passCount++;
    checkCount++;
  endtask

  task automatic test_invalid();
    board = '0;
    runOp(1'b0, 1'b1, 3'd7, 2'd1, 10);
    if (wrCount != 0 || doneCycle != 1 || doneOkSeen !== 1'b0)
      $display("FAIL invalid_col: got writes=%0d cycle=%0d ok=%b expected 0/1/0", wrCount, doneCycle, doneOkSeen);
    else passCount++;
    checkCount++;
    runOp(1'b0, 1'b1, 3'd2, 2'd0, 10);
    if (wrCount != 0 || doneCycle != 1 || doneOkSeen !== 1'b0)
      $display("FAIL invalid_player0: got writes=%0d cycle=%0d ok=%b expected 0/1/0", wrCount, doneCycle, doneOkSeen);
    else passCount++;
    checkCount++;
    runOp(1'b0, 1'b1, 3'd2, 2'd3, 10);
    if (wrCount != 0 || doneCycle != 1 || doneOkSeen !== 1'b0)
      $display("FAIL invalid_player3: got writes=%0d cycle=%0d ok=%b expected 0/1/0", wrCount, doneCycle, doneOkSeen);
    else passCount++;
    checkCount++;
  endtask

  task automatic test_top_row();
    board = '0;
    for (int r = 0; r < 5; r++) setCell(r, 0, 32'd2);
    runOp(1'b0, 1'b1, 3'd0, 2'd1, 20);
    if (wrCycle != 7 || firstAddr != 35 || wrData !== 32'd1)
      $display("FAIL top_row_wr: got cycle=%0d addr=%0d data=%0h expected 7/35/1", wrCycle, firstAddr, wrData);
    else passCount++;
    checkCount++;
    if (doneCycle != 8 || doneOkSeen !== 1'b1 || doneRowSeen !== 3'd5)
      $display("FAIL top_row_done: got cycle=%0d ok=%b row=%0d expected 8/1/5", doneCycle, doneOkSeen, doneRowSeen);
    else passCount++;
    checkCount++;
  endtask

  task automatic test_clear_priority();
    board = '0;
    setCell(0, 2, 32'd1);
    setCell(3, 4, 32'd2);
    runOp(1'b1, 1'b1, 3'd2, 2'd1, 60);
    if (wrCount != 42 || wrCycle != 1)
      $display("FAIL clear_count: got writes=%0d first=%0d expected 42/1", wrCount, wrCycle);
    else passCount++;
    checkCount++;
    if (firstAddr != 0 || lastAddr != 41 || seqOk !== 1'b1)
      $display("FAIL clear_addrs: got first=%0d last=%0d seq=%b expected 0/41/1", firstAddr, lastAddr, seqOk);
    else passCount++;
    checkCount++;
    if (zeroOk !== 1'b1) $display("FAIL clear_data: got nonzero write data expected 0");
    else passCount++;
    checkCount++;
    if (doneCycle != 43 || doneOkSeen !== 1'b1 || doneRowSeen !== 3'd0)
      $display("FAIL clear_done: got cycle=%0d ok=%b row=%0d expected 43/1/0", doneCycle, doneOkSeen, doneRowSeen);
    else passCount++;
    checkCount++;
    wrCount = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (memwrite_en || done_valid) wrCount++;
    end
    if (wrCount != 0)
      $display("FAIL clear_req_dropped: got %0d later write/done cycles expected 0", wrCount);
    else passCount++;
    checkCount++;
  endtask

  task automatic test_reset_during_clear();
    logic reached;
    int   activity;
    reached = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (memwrite_en && addr == 8'd10) begin
        reached = 1'b1;
        break;
      end
    end
    if (reached !== 1'b1) $display("FAIL rst_clear_reach: got no write to addr 10 expected one");
    else passCount++;
    checkCount++;
    #1;
    rst_n = 1'b0;
    #1;
    if (memwrite_en !== 1'b0 || req_ready !== 1'b1 || done_valid !== 1'b0)
      $display("FAIL rst_clear_abort: got wen=%b ready=%b done=%b expected 0/1/0", memwrite_en, req_ready, done_valid);
    else passCount++;
    checkCount++;
    @(negedge clk);
    rst_n = 1'b1;
    activity = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (memwrite_en || done_valid || !req_ready) activity++;
    end
    if (activity != 0)
      $display("FAIL rst_clear_idle: got %0d active cycles after reset expected 0", activity);
    else passCount++;
    checkCount++;
  endtask

  task automatic test_back_to_back();
    board = '0;
    runOp(1'b0, 1'b1, 3'd0, 2'd1, 20);
    if (firstAddr != 0 || doneCycle != 3 || doneRowSeen !== 3'd0)
      $display("FAIL b2b_first: got addr=%0d cycle=%0d row=%0d expected 0/3/0", firstAddr, doneCycle, doneRowSeen);
    else passCount++;
    checkCount++;
    setCell(0, 0, 32'd1);
    runOp(1'b0, 1'b1, 3'd0, 2'd2, 20);
    if (readyAtReq !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", readyAtReq);
    else passCount++;
    checkCount++;
    if (wrCycle != 3 || firstAddr != 7 || wrData !== 32'd2)
      $display("FAIL b2b_second_wr: got cycle=%0d addr=%0d data=%0h expected 3/7/2", wrCycle, firstAddr, wrData);
    else passCount++;
    checkCount++;
    if (doneCycle != 4 || doneOkSeen !== 1'b1 || doneRowSeen !== 3'd1)
      $display("FAIL b2b_second_done: got cycle=%0d ok=%b row=%0d expected 4/1/1", doneCycle, doneOkSeen, doneRowSeen);
    else passCount++;
    checkCount++;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    test_reset();
    test_empty_drop();
    test_stacked_drop();
    test_full_column();
    test_invalid();
    test_top_row();
    test_clear_priority();
    test_reset_during_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
